// File: rtl/wash_pkg.sv
// Shared definitions for the wash-machine timer blocks: digit width, BCD
// limit, phase-timer state encoding and the load clamp helper.
package wash_pkg;

  localparam int              BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    PAUSED   = 2'b10,
    FINISHED = 2'b11
  } state_e;

  // Any non-BCD digit (A..F) is stored as 9 so the count stays valid BCD.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/counter10_down.sv
// Single BCD digit down counter with synchronous load and borrow out.
// Wraps 0 -> 9 on an enabled step; BO tells the next digit to step.
module counter10_down
  import wash_pkg::*;
(
  input  logic             CP,
  input  logic             CR,
  input  logic             EN,
  input  logic             LD,
  input  logic [BCD_W-1:0] D,
  output logic [BCD_W-1:0] Q,
  output logic             BO
);

  logic [BCD_W-1:0] q_q;

  // Digit register: load has priority over a count step.
  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      q_q <= '0;
    end else if (LD) begin
      q_q <= D;
    end else if (EN) begin
      q_q <= (q_q == '0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  assign Q  = q_q;
  assign BO = EN && (q_q == '0);

endmodule

// File: rtl/wash_timer_down.sv
// Two-digit BCD countdown timer for one wash phase. Loaded with 00..99,
// steps down once per TICK while running, and reports completion with a
// level (DONE) and a one-cycle entry pulse (DONE_P).
module wash_timer_down
  import wash_pkg::*;
(
  input  logic             CP,
  input  logic             CR,
  input  logic             LD,
  input  logic [BCD_W-1:0] LD_TENS,
  input  logic [BCD_W-1:0] LD_ONES,
  input  logic             START,
  input  logic             PAUSE,
  input  logic             TICK,
  output logic [BCD_W-1:0] Q_TENS,
  output logic [BCD_W-1:0] Q_ONES,
  output logic             RUNNING,
  output logic             DONE,
  output logic             DONE_P
);

  state_e           state_q;
  logic             running_q;
  logic             done_q;
  logic             done_p_q;

  logic             load_en;
  logic             dec_en;
  logic             ones_bo;
  logic             tens_bo;
  logic             cnt_zero;
  logic             cnt_one;
  logic [BCD_W-1:0] ld_tens_d;
  logic [BCD_W-1:0] ld_ones_d;
  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] ones;

  assign ld_tens_d = bcd_clamp(LD_TENS);
  assign ld_ones_d = bcd_clamp(LD_ONES);

  // Load is honoured only in IDLE/FINISHED; decrement only while running.
  // NOTE: both strobes get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    load_en = 1'b0;
    dec_en  = 1'b0;
    unique case (state_q)
      IDLE, FINISHED: load_en = LD;
      RUN:            dec_en  = TICK;
      default:        ;
    endcase
  end

  counter10_down u_ones (
    .CP (CP),
    .CR (CR),
    .EN (dec_en),
    .LD (load_en),
    .D  (ld_ones_d),
    .Q  (ones),
    .BO (ones_bo)
  );

  counter10_down u_tens (
    .CP (CP),
    .CR (CR),
    .EN (ones_bo),
    .LD (load_en),
    .D  (ld_tens_d),
    .Q  (tens),
    .BO (tens_bo)
  );

  assign cnt_zero = (tens == '0) && (ones == '0);
  assign cnt_one  = (tens == '0) && (ones == 4'd1);

  // Phase state machine with registered status outputs. tens_bo can only
  // fire on a tick at 00, which RUN never sees; it is folded into the
  // finish condition so such a step still terminates the phase.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      done_p_q  <= 1'b0;
    end else begin
      done_p_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!LD && START && !cnt_zero) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (TICK && (cnt_one || tens_bo)) begin
            state_q   <= FINISHED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            done_p_q  <= 1'b1;
          end else if (PAUSE) begin
            state_q   <= PAUSED;
            running_q <= 1'b0;
          end
        end
        PAUSED: begin
          if (START || PAUSE) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        FINISHED: begin
          if (LD) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q_TENS  = tens;
  assign Q_ONES  = ones;
  assign RUNNING = running_q;
  assign DONE    = done_q;
  assign DONE_P  = done_p_q;

endmodule

// File: tb/tb_wash_timer_down.sv
// Scoreboard bench for wash_timer_down: each stimulus cycle pushes the
// hand-computed post-edge snapshot {tens, ones, RUNNING, DONE, DONE_P};
// a monitor pops and compares it just after the sampling edge.
module tb_wash_timer_down;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       LD = 1'b0;
  logic [3:0] LD_TENS = '0;
  logic [3:0] LD_ONES = '0;
  logic       START = 1'b0;
  logic       PAUSE = 1'b0;
  logic       TICK = 1'b0;
  logic [3:0] Q_TENS;
  logic [3:0] Q_ONES;
  logic       RUNNING;
  logic       DONE;
  logic       DONE_P;

  wash_timer_down dut (
    .CP      (CP),
    .CR      (CR),
    .LD      (LD),
    .LD_TENS (LD_TENS),
    .LD_ONES (LD_ONES),
    .START   (START),
    .PAUSE   (PAUSE),
    .TICK    (TICK),
    .Q_TENS  (Q_TENS),
    .Q_ONES  (Q_ONES),
    .RUNNING (RUNNING),
    .DONE    (DONE),
    .DONE_P  (DONE_P)
  );

  always #5 CP = ~CP;

  typedef struct {
    string      name;
    logic [10:0] exp;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [10:0] snap;

  assign snap = {Q_TENS, Q_ONES, RUNNING, DONE, DONE_P};

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d%0d run=%b done=%b dp=%b, expected %0d%0d run=%b done=%b dp=%b",
               name, got[10:7], got[6:3], got[2], got[1], got[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare the pending expectation just after each rising edge.
  always @(posedge CP) begin
    sb_entry_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, snap, e.exp);
    end
  end

  // Drive one cycle of inputs and queue the expected state after its edge.
  task automatic step(input string name, input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                      input logic st, input logic pa, input logic tk,
                      input logic [3:0] et, input logic [3:0] eo,
                      input logic er, input logic ed, input logic ep);
    sb_entry_t e;
    @(negedge CP);
    LD = ld; LD_TENS = lt; LD_ONES = lo;
    START = st; PAUSE = pa; TICK = tk;
    e.name = name;
    e.exp  = {et, eo, er, ed, ep};
    sb_q.push_back(e);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
  task automatic pulse_reset(input string name);
    @(negedge CP);
    LD = 1'b0; START = 1'b0; PAUSE = 1'b0; TICK = 1'b0;
    CR = 1'b1;
    #1;
    check(name, snap, 11'd0);
    @(negedge CP);
    CR = 1'b0;
  endtask

  initial begin
    int v;
    #1;
    check("reset_initial", snap, 11'd0);
    repeat (2) @(negedge CP);
    CR = 1'b0;

    // Get to 37 in RUN, then reset mid-run; START at 00 must be ignored.
    step("ld37",     1, 4'd3, 4'd7, 0, 0, 0, 4'd3, 4'd7, 0, 0, 0);
    step("start37",  0, 4'd0, 4'd0, 1, 0, 0, 4'd3, 4'd7, 1, 0, 0);
    step("run37",    0, 4'd0, 4'd0, 0, 0, 0, 4'd3, 4'd7, 1, 0, 0);
    pulse_reset("rst_in_run");
    step("start_at_00", 0, 4'd0, 4'd0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0);

    // 25 down through the 20 -> 19 borrow.
    step("ld25",     1, 4'd2, 4'd5, 0, 0, 0, 4'd2, 4'd5, 0, 0, 0);
    step("start25",  0, 4'd0, 4'd0, 1, 0, 0, 4'd2, 4'd5, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      v = 24 - i;
      step("tick25", 0, 4'd0, 4'd0, 0, 0, 1, 4'(v / 10), 4'(v % 10), 1, 0, 0);
      step("hold25", 0, 4'd0, 4'd0, 0, 0, 0, 4'(v / 10), 4'(v % 10), 1, 0, 0);
    end
    step("ld_in_run",   1, 4'd5, 4'd5, 0, 0, 0, 4'd1, 4'd9, 1, 0, 0);
    step("pause19",     0, 4'd0, 4'd0, 0, 1, 0, 4'd1, 4'd9, 0, 0, 0);
    step("resume_both", 0, 4'd0, 4'd0, 1, 1, 0, 4'd1, 4'd9, 1, 0, 0);

    // 02 to completion; DONE_P exactly one cycle, ticks then ignored.
    pulse_reset("rst_before_02");
    step("ld02",      1, 4'd0, 4'd2, 0, 0, 0, 4'd0, 4'd2, 0, 0, 0);
    step("start02",   0, 4'd0, 4'd0, 1, 0, 0, 4'd0, 4'd2, 1, 0, 0);
    step("tick02",    0, 4'd0, 4'd0, 0, 0, 1, 4'd0, 4'd1, 1, 0, 0);
    step("hold01",    0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0);
    step("tick01",    0, 4'd0, 4'd0, 0, 0, 1, 4'd0, 4'd0, 0, 1, 1);
    step("done_hold", 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    step("done_tick", 0, 4'd0, 4'd0, 0, 0, 1, 4'd0, 4'd0, 0, 1, 0);
    step("done_hold2",0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    step("done_ign",  0, 4'd0, 4'd0, 1, 1, 1, 4'd0, 4'd0, 0, 1, 0);
    step("fin_ld15",  1, 4'd1, 4'd5, 0, 0, 0, 4'd1, 4'd5, 0, 0, 0);
    step("start15",   0, 4'd0, 4'd0, 1, 0, 0, 4'd1, 4'd5, 1, 0, 0);

    // Tick+pause at 10, ticks ignored while paused, resume and step.
    pulse_reset("rst_before_10");
    step("ld10",       1, 4'd1, 4'd0, 0, 0, 0, 4'd1, 4'd0, 0, 0, 0);
    step("start10",    0, 4'd0, 4'd0, 1, 0, 0, 4'd1, 4'd0, 1, 0, 0);
    step("tick_pause", 0, 4'd0, 4'd0, 0, 1, 1, 4'd0, 4'd9, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("paused_hold", 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 4'd9, 0, 0, 0);
      step("paused_tick", 1, 4'd4, 4'd4, 0, 0, 1, 4'd0, 4'd9, 0, 0, 0);
    end
    step("resume09",   0, 4'd0, 4'd0, 1, 0, 0, 4'd0, 4'd9, 1, 0, 0);
    step("tick09",     0, 4'd0, 4'd0, 0, 0, 1, 4'd0, 4'd8, 1, 0, 0);

    // Load clamp with simultaneous START: load wins, stays IDLE.
    pulse_reset("rst_before_clamp");
    step("ld_c3_start", 1, 4'hC, 4'h3, 1, 0, 0, 4'd9, 4'd3, 0, 0, 0);
    step("idle93",      0, 4'd0, 4'd0, 0, 0, 0, 4'd9, 4'd3, 0, 0, 0);
    step("start93",     0, 4'd0, 4'd0, 1, 0, 0, 4'd9, 4'd3, 1, 0, 0);
    pulse_reset("rst_before_af");
    step("ld_af",       1, 4'hA, 4'hF, 0, 0, 0, 4'd9, 4'd9, 0, 0, 0);

    // Tick at 01 with pause: FINISHED wins; then reset out of FINISHED.
    pulse_reset("rst_before_01");
    step("ld01",        1, 4'd0, 4'd1, 0, 0, 0, 4'd0, 4'd1, 0, 0, 0);
    step("start01",     0, 4'd0, 4'd0, 1, 0, 0, 4'd0, 4'd1, 1, 0, 0);
    step("tick01_pause",0, 4'd0, 4'd0, 0, 1, 1, 4'd0, 4'd0, 0, 1, 1);
    step("fin_hold",    0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    step("fin_pause",   0, 4'd0, 4'd0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 0);
    pulse_reset("rst_from_finished");

    @(negedge CP);
    LD = 1'b0; START = 1'b0; PAUSE = 1'b0; TICK = 1'b0;
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge CP);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wash_timer_down.md
# wash_timer_down

Two-digit BCD countdown timer for the wash machine controller: the down-counting counterpart of the up-counting `counter10` digit counter. It is loaded with a wash-phase duration (00–99), counts down one unit per `TICK` strobe, and flags completion. It sits between the front-end divider that generates `TICK` and the wash-phase sequencer that loads durations and consumes `DONE`.

## Interface
Parameters:
- none; the width is fixed at two BCD digits, 4 bits per digit.

Ports:
- `CP`  in  1  clock; all state changes on the rising edge.
- `CR`  in  1  reset; asynchronous, active-high.
- `LD`  in  1  load strobe; copies `LD_TENS`/`LD_ONES` into the count.
- `LD_TENS`  in  4  tens digit to load.
- `LD_ONES`  in  4  ones digit to load.
- `START`  in  1  one-cycle start/resume request.
- `PAUSE`  in  1  one-cycle pause request.
- `TICK`  in  1  one-cycle count strobe from the divider; never high two cycles in a row.
- `Q_TENS`  out  4  current tens digit, BCD.
- `Q_ONES`  out  4  current ones digit, BCD.
- `RUNNING`  out  1  high while in RUN.
- `DONE`  out  1  high while in FINISHED.
- `DONE_P`  out  1  one-cycle pulse on entry to FINISHED.

## Operation
- State machine:
  - IDLE: `LD` loads the count. `START` with a nonzero count goes to RUN. `START` with a count of 00 is ignored.
  - RUN: `TICK` decrements the count. A `TICK` at count 01 writes 00 and goes to FINISHED. `PAUSE` goes to PAUSED. `LD` is ignored.
  - PAUSED: `TICK` and `LD` are ignored. `START` or `PAUSE` returns to RUN.
  - FINISHED: the count holds at 00. `LD` loads and goes to IDLE. `START`, `PAUSE` and `TICK` are ignored.
- Decrement rules:
  - Ones 1–9: ones decrements.
  - Ones 0: ones becomes 9, and tens decrements (borrow).
  - Count 00 is never decremented, because RUN is never entered at 00.
- Load clamp: any loaded digit greater than 9 is stored as 9 (so 4'hC loads as 9).
- Simultaneous events, in priority order:
  - IDLE, `LD` and `START` together: the load happens and `START` is dropped that cycle.
  - RUN, `TICK` and `PAUSE` together: the decrement is applied, then the state moves to PAUSED.
  - RUN, `TICK` at 01 and `PAUSE` together: FINISHED wins.
  - PAUSED, `START` and `PAUSE` together: resume to RUN.
- Reset mid-operation: `CR` immediately forces count 00 and IDLE, with every output low. There is no resume after reset.

## Timing
- Reset values:
  - `Q_TENS` = 0, `Q_ONES` = 0
  - `RUNNING` = 0, `DONE` = 0, `DONE_P` = 0
  - state = IDLE
- All outputs are registered and change only on the rising edge of `CP`, except on assertion of `CR`.
- Latency:
  - The count changes on the edge that samples `TICK`, `LD`, or the decisive input.
  - `RUNNING` and `DONE` reflect the new state in the cycle after the sampling edge.
- `DONE_P` is high for exactly one cycle: the first cycle in which `DONE` is high.
- All inputs are synchronous to `CP`. External buttons are synchronised upstream.

## Structure
- Shared package `wash_pkg`:
  - state encoding: IDLE=2'b00, RUN=2'b01, PAUSED=2'b10, FINISHED=2'b11
  - constant `BCD_W`=4
  - constant `BCD_MAX`=4'd9
- One sub-module, `counter10_down`: a single-digit BCD down counter.
  - Ports: `CP`, `CR`, `EN`, `LD`, `D[3:0]` in; `Q[3:0]`, `BO` out.
  - `BO` = `EN` and (`Q`==0), i.e. a borrow out.
  - The block instantiates two of these in a chain: the ones digit's `BO` drives the tens digit's `EN`.
- The top level holds the state machine, the load clamp, the zero/one detect, and the `DONE_P` edge logic.

## Test plan
- Reset: assert `CR` mid-count at 37 in RUN. Required: 00, IDLE, all outputs 0 with no wait for a clock edge. After `CR` is released, `START` is ignored.
- Load 25, then `START`, then 6 `TICK`s. Required sequence: 24, 23, 22, 21, 20, 19. The 20→19 step checks the borrow. `RUNNING`=1 throughout.
- Load 02, `START`, 2 `TICK`s. Required:
  - count reaches 00;
  - `DONE`=1 from the next cycle;
  - `DONE_P` high for exactly 1 cycle;
  - further `TICK`s keep 00.
- Pause and resume:
  - In RUN at 10, assert `PAUSE` with `TICK` in the same cycle. Required: 09, PAUSED.
  - Then 3 `TICK`s. Required: count stays 09.
  - Then `START`, then one `TICK`. Required: 08.
- Load clamp and priority:
  - `LD` with tens=4'hC, ones=4'h3 together with `START` in IDLE. Required: count 93, state IDLE.
  - `START` at 00 in IDLE. Required: ignored.
  - `LD` during RUN. Required: ignored.
- From FINISHED, `LD` 15. Required: IDLE, count 15, `DONE`=0.
